col_maxpool: RTL and testbench
==============================

Name: col_maxpool

Overview:
- Downstream neighbour of the column transpose stage in the CNN datapath.
- Consumes the 11 transposed columns of 28 signed elements each.
- Applies max-pooling of POOL consecutive elements along each column, giving 11 columns of 14 elements for the next layer.
- Uses the same start/done handshake as the transpose stage. It snapshots its inputs once, so upstream may change them afterwards.

Parameters:
- DATA_W, 16, element width (signed two's complement)
- ROWS, 28, elements per input column
- COLS, 11, number of columns; the port list is fixed at 11
- POOL, 2, pooling window and stride along the column; OUT_ROWS = ROWS/POOL (floor); ROWS >= POOL required

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE and DONE
- busy  out  1  high in LOAD and POOL
- done  out  1  registered; high while in DONE
- in_col0..in_col10  in  DATA_W x [0:ROWS-1] each, signed  transposed columns from upstream
- out_col0..out_col10  out  DATA_W x [0:OUT_ROWS-1] each, signed  pooled columns

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state=IDLE, row counter=0, done=0, busy=0.
  - All out_colC[r]=0 and the snapshot buffer is cleared.
  - Reset overrides everything, including mid-operation: the partial result is discarded and outputs return to 0.
- States: IDLE, LOAD, POOL, DONE.
  - IDLE: start=1 -> LOAD; otherwise stay.
  - LOAD: copy all in_colC[0:ROWS-1] into the internal snapshot -> POOL; row counter=0.
  - POOL: each cycle writes out_colC[r] = max(snap_C[r*POOL .. r*POOL+POOL-1]) for every C in parallel, then r++. The cycle that writes r=OUT_ROWS-1 moves to DONE and sets done=1 at the same edge.
  - DONE: done held at 1 and outputs stable. start=1 -> LOAD and clears done at that edge. Otherwise stay.
- Latency: with start sampled at edge 0, LOAD is edge 1 and POOL writes are edges 2..OUT_ROWS+1. done is visible after edge OUT_ROWS+1, i.e. 15 cycles for the defaults.
- start is ignored while busy; no queuing.
- Comparison:
  - Full-width signed comparison; no truncation, output width = DATA_W.
  - Ties keep the lowest-index element. Values are bit-identical either way, but a tie must not toggle the register.
- Odd ROWS: trailing ROWS mod POOL elements are ignored.
- Outputs keep previous-run values until overwritten row by row during a new POOL phase. Consumers read only while done=1.
- Input changes after the LOAD edge have no effect on the current run.

Optional Feature:
- Macro: COL_MAXPOOL_RELU_EN.
- Defined: each pooled value passes through ReLU before the register write (negative -> 0, else unchanged), fusing the activation into this stage.
- Undefined: raw signed max is written; negative results are preserved.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 for 20 cycles -> done=0, busy=0, all 154 outputs = 0.
- Ramp: in_colC[r] = C*100 + r, start pulse -> done rises exactly 15 cycles later; out_colC[k] = C*100 + 2k+1 (e.g. out_col10[13]=1027).
- Negatives: in_col0 = {-5, -3, -32768, -1, ...}, start -> out_col0[0]=-3, out_col0[1]=-1. With COL_MAXPOOL_RELU_EN defined, both = 0.
- Snapshot and ignore: start, then at the LOAD+1 cycle change all inputs to 0x7FFF and pulse start again -> outputs reflect the original data, and a single done rise at 15 cycles.
- Restart from DONE: after run 1 (ramp), set all inputs to -7 and pulse start -> done drops at the next edge and re-rises 15 cycles later; all outputs = -7 (0 under RELU_EN).
- Mid-run reset: assert rst during the 5th POOL cycle -> at the next edge all outputs = 0, done=0, IDLE. A following start gives the correct full result.

Source files
------------

// File: rtl/col_maxpool.sv
// col_maxpool: snapshots 11 columns of ROWS signed elements and max-pools POOL consecutive elements per column; define COL_MAXPOOL_RELU_EN to fuse ReLU into the write
module col_maxpool #(
  parameter int DATA_W = 16,
  parameter int ROWS = 28,
  parameter int COLS = 11,
  parameter int POOL = 2,
  localparam int OUT_ROWS = ROWS / POOL
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  input  logic signed [DATA_W-1:0] in_col0 [0:ROWS-1],
  input  logic signed [DATA_W-1:0] in_col1 [0:ROWS-1],
  input  logic signed [DATA_W-1:0] in_col2 [0:ROWS-1],
  input  logic signed [DATA_W-1:0] in_col3 [0:ROWS-1],
  input  logic signed [DATA_W-1:0] in_col4 [0:ROWS-1],
  input  logic signed [DATA_W-1:0] in_col5 [0:ROWS-1],
  input  logic signed [DATA_W-1:0] in_col6 [0:ROWS-1],
  input  logic signed [DATA_W-1:0] in_col7 [0:ROWS-1],
  input  logic signed [DATA_W-1:0] in_col8 [0:ROWS-1],
  input  logic signed [DATA_W-1:0] in_col9 [0:ROWS-1],
  input  logic signed [DATA_W-1:0] in_col10 [0:ROWS-1],
  output logic signed [DATA_W-1:0] out_col0 [0:OUT_ROWS-1],
  output logic signed [DATA_W-1:0] out_col1 [0:OUT_ROWS-1],
  output logic signed [DATA_W-1:0] out_col2 [0:OUT_ROWS-1],
  output logic signed [DATA_W-1:0] out_col3 [0:OUT_ROWS-1],
  output logic signed [DATA_W-1:0] out_col4 [0:OUT_ROWS-1],
  output logic signed [DATA_W-1:0] out_col5 [0:OUT_ROWS-1],
  output logic signed [DATA_W-1:0] out_col6 [0:OUT_ROWS-1],
  output logic signed [DATA_W-1:0] out_col7 [0:OUT_ROWS-1],
  output logic signed [DATA_W-1:0] out_col8 [0:OUT_ROWS-1],
  output logic signed [DATA_W-1:0] out_col9 [0:OUT_ROWS-1],
  output logic signed [DATA_W-1:0] out_col10 [0:OUT_ROWS-1]
);
  localparam int RW = $clog2(OUT_ROWS + 1);
  localparam int IW = $clog2(ROWS + 1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_POOL, S_DONE} state_t;
  state_t st_q;
  logic [RW-1:0] r_q;
  logic signed [DATA_W-1:0] snap_q [COLS][ROWS];
  logic signed [DATA_W-1:0] mx [COLS];
  logic signed [DATA_W-1:0] pv [COLS];
  // window max for the current output row; strict > keeps the lowest-index element on ties
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      mx[c] = snap_q[c][IW'(int'(r_q) * POOL)];
      for (int j = 1; j < POOL; j++)
        mx[c] = (snap_q[c][IW'(int'(r_q) * POOL + j)] > mx[c]) ? snap_q[c][IW'(int'(r_q) * POOL + j)] : mx[c];
`ifdef COL_MAXPOOL_RELU_EN
      pv[c] = mx[c][DATA_W-1] ? '0 : mx[c];
`else
      pv[c] = mx[c];
`endif
    end
  end
  // control FSM, input snapshot and row-by-row output writes
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
      r_q <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      for (int c = 0; c < COLS; c++)
        for (int r = 0; r < ROWS; r++)
          snap_q[c][r] <= '0;
      for (int r = 0; r < OUT_ROWS; r++) begin
        out_col0[r] <= '0;
        out_col1[r] <= '0;
        out_col2[r] <= '0;
        out_col3[r] <= '0;
        out_col4[r] <= '0;
        out_col5[r] <= '0;
        out_col6[r] <= '0;
        out_col7[r] <= '0;
        out_col8[r] <= '0;
        out_col9[r] <= '0;
        out_col10[r] <= '0;
      end
    end else begin
      case (st_q)
        S_IDLE: if (start) begin
          st_q <= S_LOAD;
          busy <= 1'b1;
        end
        S_LOAD: begin
          for (int r = 0; r < ROWS; r++) begin
            snap_q[0][r] <= in_col0[r];
            snap_q[1][r] <= in_col1[r];
            snap_q[2][r] <= in_col2[r];
            snap_q[3][r] <= in_col3[r];
            snap_q[4][r] <= in_col4[r];
            snap_q[5][r] <= in_col5[r];
            snap_q[6][r] <= in_col6[r];
            snap_q[7][r] <= in_col7[r];
            snap_q[8][r] <= in_col8[r];
            snap_q[9][r] <= in_col9[r];
            snap_q[10][r] <= in_col10[r];
          end
          r_q <= '0;
          st_q <= S_POOL;
        end
        S_POOL: begin
          out_col0[r_q] <= pv[0];
          out_col1[r_q] <= pv[1];
          out_col2[r_q] <= pv[2];
          out_col3[r_q] <= pv[3];
          out_col4[r_q] <= pv[4];
          out_col5[r_q] <= pv[5];
          out_col6[r_q] <= pv[6];
          out_col7[r_q] <= pv[7];
          out_col8[r_q] <= pv[8];
          out_col9[r_q] <= pv[9];
          out_col10[r_q] <= pv[10];
          if (r_q == RW'(OUT_ROWS - 1)) begin
            r_q <= '0;
            st_q <= S_DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            r_q <= r_q + 1'b1;
          end
        end
        default: if (start) begin
          st_q <= S_LOAD;
          done <= 1'b0;
          busy <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_col_maxpool.sv
// tb_col_maxpool: directed and randomized checks of col_maxpool against a column max-pool reference
module tb_col_maxpool;
  localparam int W = 16, R = 28, C = 11, P = 2, O = R / P;
  logic clk = 0, rst = 1, start = 0, busy, done;
  logic signed [W-1:0] in_m [C][R];
  logic signed [W-1:0] saved [C][R];
  logic signed [W-1:0] out_m [C][O];
  logic signed [W-1:0] in_col0 [0:R-1], in_col1 [0:R-1], in_col2 [0:R-1], in_col3 [0:R-1];
  logic signed [W-1:0] in_col4 [0:R-1], in_col5 [0:R-1], in_col6 [0:R-1], in_col7 [0:R-1];
  logic signed [W-1:0] in_col8 [0:R-1], in_col9 [0:R-1], in_col10 [0:R-1];
  logic signed [W-1:0] out_col0 [0:O-1], out_col1 [0:O-1], out_col2 [0:O-1], out_col3 [0:O-1];
  logic signed [W-1:0] out_col4 [0:O-1], out_col5 [0:O-1], out_col6 [0:O-1], out_col7 [0:O-1];
  logic signed [W-1:0] out_col8 [0:O-1], out_col9 [0:O-1], out_col10 [0:O-1];
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  col_maxpool dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_col0(in_col0), .in_col1(in_col1), .in_col2(in_col2), .in_col3(in_col3),
    .in_col4(in_col4), .in_col5(in_col5), .in_col6(in_col6), .in_col7(in_col7),
    .in_col8(in_col8), .in_col9(in_col9), .in_col10(in_col10),
    .out_col0(out_col0), .out_col1(out_col1), .out_col2(out_col2), .out_col3(out_col3),
    .out_col4(out_col4), .out_col5(out_col5), .out_col6(out_col6), .out_col7(out_col7),
    .out_col8(out_col8), .out_col9(out_col9), .out_col10(out_col10)
  );
  always_comb begin
    for (int r = 0; r < R; r++) begin
      in_col0[r] = in_m[0][r];
      in_col1[r] = in_m[1][r];
      in_col2[r] = in_m[2][r];
      in_col3[r] = in_m[3][r];
      in_col4[r] = in_m[4][r];
      in_col5[r] = in_m[5][r];
      in_col6[r] = in_m[6][r];
      in_col7[r] = in_m[7][r];
      in_col8[r] = in_m[8][r];
      in_col9[r] = in_m[9][r];
      in_col10[r] = in_m[10][r];
    end
  end
  always_comb begin
    for (int k = 0; k < O; k++) begin
      out_m[0][k] = out_col0[k];
      out_m[1][k] = out_col1[k];
      out_m[2][k] = out_col2[k];
      out_m[3][k] = out_col3[k];
      out_m[4][k] = out_col4[k];
      out_m[5][k] = out_col5[k];
      out_m[6][k] = out_col6[k];
      out_m[7][k] = out_col7[k];
      out_m[8][k] = out_col8[k];
      out_m[9][k] = out_col9[k];
      out_m[10][k] = out_col10[k];
    end
  end
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int relu(input int v);
`ifdef COL_MAXPOOL_RELU_EN
    return v < 0 ? 0 : v;
`else
    return v;
`endif
  endfunction
  function automatic int model(input int c, input int k);
    int m = saved[c][k*P];
    for (int i = 1; i < P; i++) if (int'(saved[c][k*P+i]) > m) m = saved[c][k*P+i];
    return relu(m);
  endfunction
  task automatic check_outs(input string tag);
    for (int c = 0; c < C; c++)
      for (int k = 0; k < O; k++)
        chk($sformatf("%s_c%0d_r%0d", tag, c, k), out_m[c][k], model(c, k));
  endtask
  task automatic check_zero(input string tag);
    for (int c = 0; c < C; c++)
      for (int k = 0; k < O; k++)
        chk($sformatf("%s_c%0d_r%0d", tag, c, k), out_m[c][k], 0);
  endtask
  task automatic fill_rand(input int mode);
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++)
        in_m[c][r] = mode == 0 ? W'($urandom) : W'($signed($urandom_range(8)) - 4);
  endtask
  task automatic go(input string tag, input bit perturb);
    int n;
    saved = in_m;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_done_e0"}, done, 0);
    for (n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (perturb && n == 1) begin
        for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) in_m[c][r] = 16'sh7FFF;
        start = 1;
      end else start = 0;
      if (done) break;
    end
    chk({tag, "_latency"}, n, 15);
    chk({tag, "_busy_done"}, busy, 0);
    check_outs(tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_hold"}, done, 1);
    chk({tag, "_hold_c5_r7"}, out_m[5][7], model(5, 7));
  endtask
  initial begin
    for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) in_m[c][r] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    check_zero("idle");
    for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) in_m[c][r] = W'(c * 100 + r);
    go("ramp", 0);
    chk("ramp_c10_r13", out_m[10][13], 1027);
    for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) in_m[c][r] = -16'sd7;
    go("minus7", 0);
    chk("minus7_c0_r0", out_m[0][0], relu(-7));
    fill_rand(0);
    in_m[0][0] = -16'sd5;
    in_m[0][1] = -16'sd3;
    in_m[0][2] = -16'sd32768;
    in_m[0][3] = -16'sd1;
    go("neg", 0);
    chk("neg_c0_r0", out_m[0][0], relu(-3));
    chk("neg_c0_r1", out_m[0][1], relu(-1));
    fill_rand(0);
    go("snap", 1);
    for (int t = 0; t < 3; t++) begin
      fill_rand(t == 1 ? 1 : 0);
      go($sformatf("rand%0d", t), 0);
    end
    fill_rand(0);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mrst_done", done, 0);
    chk("mrst_busy", busy, 0);
    check_zero("mrst");
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_idle_done", done, 0);
    chk("mrst_idle_busy", busy, 0);
    go("after_rst", 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
